// File: rtl/bus_control_sequencer.sv
// T-state control unit for the shared 32-bit datapath bus.
// Emits bus-out selects, load enables and ALU op per T-step.
module bus_control_sequencer #(
  parameter int OPW          = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           run,
  input  logic [31:0]    ir,
  input  logic           mem_done,
  output logic           PCout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           Rout,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           PCin,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           Yin,
  output logic           Zin,
  output logic           HIin,
  output logic           LOin,
  output logic           Rin,
  output logic           IncPC,
  output logic           mem_read,
  output logic [OPW-1:0] alu_op,
  output logic           busy,
  output logic [1:0]     fault,
  output logic [15:0]    instr_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_FAULT
  } state_t;

  localparam logic [OPW-1:0] OP_SHIFT_MAX = OPW'('h07);
  localparam logic [OPW-1:0] OP_MUL       = OPW'('h0F);
  localparam logic [OPW-1:0] OP_DIV       = OPW'('h10);
  localparam logic [OPW-1:0] OP_NEG       = OPW'('h11);
  localparam logic [OPW-1:0] OP_NOT       = OPW'('h12);
  localparam logic [7:0]     WAIT_LAST    = 8'(MEM_WAIT_MAX - 1);

  state_t         state;
  logic [7:0]     wait_cnt;
  logic [OPW-1:0] op_q;

  logic [OPW-1:0] opc;
  logic           opc_legal;
  logic           opc_unary;
  logic           q_muldiv;
  logic           unused_ir;

  assign opc       = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];

  assign opc_unary = (opc == OP_NEG) || (opc == OP_NOT);
  assign opc_legal = (opc <= OP_SHIFT_MAX) ||
                     (opc == OP_MUL) ||
                     (opc == OP_DIV) ||
                     opc_unary;
  assign q_muldiv  = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      op_q        <= '0;
      fault       <= 2'd0;
      instr_count <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run) state <= S_T0;
        end
        S_T0: begin
          wait_cnt <= 8'd0;
          state    <= S_T1;
        end
        S_T1: begin
          // a late mem_done still beats the timeout
          if (mem_done) begin
            state <= S_T2;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_FAULT;
            fault <= 2'd2;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_T2: begin
          wait_cnt <= 8'd0;
          state    <= S_T3;
        end
        S_T3: begin
          op_q <= opc;
          if (!opc_legal) begin
            state <= S_FAULT;
            fault <= 2'd1;
          end else if (opc_unary) begin
            state <= S_T5;
          end else begin
            state <= S_T4;
          end
        end
        S_T4: begin
          state <= S_T5;
        end
        S_T5: begin
          if (q_muldiv) begin
            state <= S_T6;
          end else begin
            instr_count <= instr_count + 16'd1;
            state       <= run ? S_T0 : S_IDLE;
          end
        end
        S_T6: begin
          instr_count <= instr_count + 16'd1;
          state       <= run ? S_T0 : S_IDLE;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // T3 is the only step that looks at ir; later steps use op_q
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    Rout     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    PCin     = 1'b0;
    IRin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = 1'b0;
    IncPC    = 1'b0;
    mem_read = 1'b0;
    alu_op   = '0;
    unique case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout  = 1'b1;
        mem_read = 1'b1;
        MDRin    = 1'b1;
        PCin     = (wait_cnt == 8'd0);
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (opc_legal) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          if (opc_unary) begin
            Zin    = 1'b1;
            alu_op = opc;
          end else begin
            Yin = 1'b1;
          end
        end
      end
      S_T4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = op_q;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (q_muldiv) begin
          LOin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_FAULT);

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Bench for bus_control_sequencer: per-cycle expected strobes,
// op, busy, fault and count generated into a queue and compared.
module tb_bus_control_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        run;
  logic [31:0] ir;
  logic        mem_done;
  logic        PCout, Zhighout, Zlowout, MDRout, Rout;
  logic        Gra, Grb, Grc;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin;
  logic        HIin, LOin, Rin, IncPC, mem_read;
  logic [4:0]  alu_op;
  logic        busy;
  logic [1:0]  fault;
  logic [15:0] instr_count;

  always #5 clock = ~clock;

  bus_control_sequencer #(.OPW(5), .MEM_WAIT_MAX(15)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir),
    .mem_done(mem_done),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .Rout(Rout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .IncPC(IncPC), .mem_read(mem_read), .alu_op(alu_op),
    .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  localparam logic [18:0] M_PCOUT = 19'(1) << 18;
  localparam logic [18:0] M_ZHI   = 19'(1) << 17;
  localparam logic [18:0] M_ZLO   = 19'(1) << 16;
  localparam logic [18:0] M_MDRO  = 19'(1) << 15;
  localparam logic [18:0] M_ROUT  = 19'(1) << 14;
  localparam logic [18:0] M_GRA   = 19'(1) << 13;
  localparam logic [18:0] M_GRB   = 19'(1) << 12;
  localparam logic [18:0] M_GRC   = 19'(1) << 11;
  localparam logic [18:0] M_PCIN  = 19'(1) << 10;
  localparam logic [18:0] M_IRIN  = 19'(1) << 9;
  localparam logic [18:0] M_MARIN = 19'(1) << 8;
  localparam logic [18:0] M_MDRIN = 19'(1) << 7;
  localparam logic [18:0] M_YIN   = 19'(1) << 6;
  localparam logic [18:0] M_ZIN   = 19'(1) << 5;
  localparam logic [18:0] M_HIIN  = 19'(1) << 4;
  localparam logic [18:0] M_LOIN  = 19'(1) << 3;
  localparam logic [18:0] M_RIN   = 19'(1) << 2;
  localparam logic [18:0] M_INCPC = 19'(1) << 1;
  localparam logic [18:0] M_MEMRD = 19'(1);

  logic [18:0] obs;
  assign obs = {PCout, Zhighout, Zlowout, MDRout, Rout,
                Gra, Grb, Grc, PCin, IRin, MARin, MDRin,
                Yin, Zin, HIin, LOin, Rin, IncPC, mem_read};

  typedef struct {
    logic        run;
    logic        md;
    logic [31:0] ir;
    logic [18:0] s;
    logic [4:0]  op;
    logic        busy;
    logic [1:0]  fault;
    logic [15:0] cnt;
  } rec_t;

  typedef struct {
    logic [4:0] op;
    int         waits;
    logic       drop;
  } row_t;

  rec_t        q[$];
  row_t        rows[8];
  int          total = 0;
  int          bad = 0;
  logic [15:0] m_cnt;
  logic [1:0]  m_fault;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input logic md,
                      input logic [31:0] iv, input logic [18:0] s,
                      input logic [4:0] op, input logic b);
    rec_t e;
    e = '{r, md, iv, s, op, b, m_fault, m_cnt};
    q.push_back(e);
  endtask

  task automatic push_idle(input logic r);
    push(r, rbit(), 32'h0, 19'h0, 5'h0, 1'b0);
  endtask

  task automatic gen_fetch(input logic [31:0] iv, input int waits);
    push(1'b1, rbit(), iv, M_PCOUT | M_MARIN | M_INCPC | M_ZIN,
         5'h0, 1'b1);
    for (int i = 0; i <= waits; i++)
      push(1'b1, (i == waits), iv,
           M_ZLO | M_MEMRD | M_MDRIN | ((i == 0) ? M_PCIN : 19'h0),
           5'h0, 1'b1);
  endtask

  task automatic gen_row(input logic [4:0] op, input int waits,
                         input logic drop);
    logic [31:0] iv;
    logic        r;
    logic        un;
    logic        md;
    iv = {op, 27'($urandom)};
    r  = !drop;
    un = (op == 5'h11) || (op == 5'h12);
    md = (op == 5'h0F) || (op == 5'h10);
    gen_fetch(iv, waits);
    push(r, rbit(), iv, M_MDRO | M_IRIN, 5'h0, 1'b1);
    if (un) begin
      push(r, rbit(), iv, M_GRB | M_ROUT | M_ZIN, op, 1'b1);
    end else begin
      push(r, rbit(), iv, M_GRB | M_ROUT | M_YIN, 5'h0, 1'b1);
      push(r, rbit(), iv, M_GRC | M_ROUT | M_ZIN, op, 1'b1);
    end
    if (md) begin
      push(r, rbit(), iv, M_ZLO | M_LOIN, 5'h0, 1'b1);
      push(r, rbit(), iv, M_ZHI | M_HIIN, 5'h0, 1'b1);
    end else begin
      push(r, rbit(), iv, M_ZLO | M_GRA | M_RIN, 5'h0, 1'b1);
    end
    m_cnt = m_cnt + 16'd1;
  endtask

  task automatic check(input rec_t e);
    logic [42:0] got;
    logic [42:0] want;
    got  = {obs, alu_op, busy, fault, instr_count};
    want = {e.s, e.op, e.busy, e.fault, e.cnt};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL outputs t=%0t got=%h want=%h", $time, got, want);
    end
    total++;
    if ($countones({PCout, Zhighout, Zlowout, MDRout, Rout}) > 1) begin
      bad++;
      $display("FAIL bus_onehot t=%0t got=%b want=at most one",
               $time, {PCout, Zhighout, Zlowout, MDRout, Rout});
    end
  endtask

  task automatic run_q();
    rec_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clock);
      run      = e.run;
      mem_done = e.md;
      ir       = e.ir;
      #1;
      check(e);
    end
  endtask

  task automatic do_reset();
    rec_t e;
    run     = 1'b0;
    reset_n = 1'b0;
    m_cnt   = 16'd0;
    m_fault = 2'd0;
    #1;
    e = '{1'b0, 1'b0, 32'h0, 19'h0, 5'h0, 1'b0, 2'd0, 16'd0};
    check(e);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    run      = 1'b0;
    mem_done = 1'b0;
    ir       = 32'h0;
    m_cnt    = 16'd0;
    m_fault  = 2'd0;

    rows[0] = '{5'h00, 0,  1'b0};
    rows[1] = '{5'h01, 3,  1'b0};
    rows[2] = '{5'h0F, 0,  1'b0};
    rows[3] = '{5'h11, 0,  1'b0};
    rows[4] = '{5'h10, 1,  1'b0};
    rows[5] = '{5'h12, 0,  1'b0};
    rows[6] = '{5'h02, 14, 1'b0};
    rows[7] = '{5'h04, 0,  1'b1};

    #12;
    do_reset();

    // back-to-back table, last row drops run mid-instruction
    push_idle(1'b1);
    for (int i = 0; i < 8; i++)
      gen_row(rows[i].op, rows[i].waits, rows[i].drop);
    push_idle(1'b0);
    push_idle(1'b0);
    run_q();

    // illegal opcode
    do_reset();
    push_idle(1'b1);
    gen_fetch({5'h1F, 27'h0}, 0);
    push(1'b1, rbit(), {5'h1F, 27'h0}, M_MDRO | M_IRIN, 5'h0, 1'b1);
    push(1'b1, rbit(), {5'h1F, 27'h0}, 19'h0, 5'h0, 1'b1);
    m_fault = 2'd1;
    for (int i = 0; i < 4; i++) push_idle(1'b1);
    run_q();

    // memory timeout
    do_reset();
    push_idle(1'b1);
    push(1'b1, 1'b0, 32'h0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN,
         5'h0, 1'b1);
    for (int i = 0; i < 15; i++)
      push(1'b1, 1'b0, 32'h0,
           M_ZLO | M_MEMRD | M_MDRIN | ((i == 0) ? M_PCIN : 19'h0),
           5'h0, 1'b1);
    m_fault = 2'd2;
    for (int i = 0; i < 3; i++) push_idle(1'b1);
    run_q();

    // reset during T4
    do_reset();
    push_idle(1'b1);
    gen_fetch(32'h0, 0);
    push(1'b1, 1'b0, 32'h0, M_MDRO | M_IRIN, 5'h0, 1'b1);
    push(1'b1, 1'b0, 32'h0, M_GRB | M_ROUT | M_YIN, 5'h0, 1'b1);
    push(1'b1, 1'b0, 32'h0, M_GRC | M_ROUT | M_ZIN, 5'h0, 1'b1);
    run_q();
    do_reset();
    push_idle(1'b0);
    push_idle(1'b0);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
